downsampler_variable_mc: RTL and testbench
==========================================

# downsampler_variable_mc

Runtime-programmable integer downsampler for channel-interleaved (TDM) AXI-Stream data, with full backpressure, frame-aligned rate changes and a per-frame `tlast`. It sits after the CIC decimator and before the compensation FIR. It keeps one complete N-channel frame out of every R input frames, so channel alignment is preserved across rate changes.

## Interface
- `DATA_WIDTH_INP`, 16, sample width.
- `DATA_WIDTH_RATE`, 16, width of the rate and phase words.
- `NUM_CHANNELS`, 2, channels per frame; ≥1; 1 degenerates to single-channel.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `s_axis_in_tdata`  in  DATA_WIDTH_INP  signed sample; channel order is 0..NUM_CHANNELS-1, repeating.
- `s_axis_in_tvalid` / `s_axis_in_tready`  in / out  1  input handshake.
- `s_axis_rate_tdata`  in  DATA_WIDTH_RATE  unsigned rate R.
- `s_axis_rate_tvalid`  in  1  rate write strobe; always accepted, so there is no tready.
- `s_axis_phase_tdata`  in  DATA_WIDTH_RATE  kept frame index within the window (only with `DOWNSAMPLER_PHASE_EN`).
- `m_axis_out_tdata`  out  DATA_WIDTH_INP  kept sample.
- `m_axis_out_tvalid` / `m_axis_out_tready`  out / in  1  output handshake.
- `m_axis_out_tlast`  out  1  marks the last channel of each output frame.

## Operation
- **Counters:**
  - `chan_idx` runs 0..NUM_CHANNELS-1 and advances on every input handshake.
  - `frame_cnt` runs 0..R-1 and advances when `chan_idx` wraps.
  - Both wrap to 0.
- **Keep rule:** all channels of a frame are kept when `frame_cnt == keep_idx`. Without `DOWNSAMPLER_PHASE_EN`, `keep_idx = R-1`. Other frames are consumed and dropped.
- **Effective rate:**
  - R=0 is treated as R=1 (pass-through).
  - Comparisons use the full DATA_WIDTH_RATE width, unsigned.
  - `rate-1` must not underflow.
- **Rate writes:**
  - A write stores R into `rate_pending` and sets `pend`. The last write before commit wins.
  - Commit happens at the first input handshake with `chan_idx==0`, i.e. at a frame boundary. On commit:
    - `rate_buf` ← `rate_pending`;
    - `frame_cnt` is evaluated as 0 for that frame;
    - `pend` clears.
  - A partially received frame is never split.
  - A write in the same cycle as a committing handshake is not applied to that handshake. It stays pending for the next boundary.
- **Output:** kept samples pass through a 2-entry skid buffer. `m_axis_out_tlast` = (`chan_idx == NUM_CHANNELS-1`) captured with the sample.
- **Backpressure:**
  - `s_axis_in_tready` = skid buffer has a free slot.
  - It is deasserted only when both entries are occupied.
  - Dropped frames are still stalled in that case (simple, deterministic).
- **Reset (asynchronous):**
  - `rate_buf`=1, `pend`=0, counters=0.
  - Outputs: `m_axis_out_tvalid`=0, `m_axis_out_tdata`=0, `m_axis_out_tlast`=0.
  - `s_axis_in_tready`=1 from the first cycle after reset deasserts.
  - Reset mid-frame discards buffered samples and the partial frame.

## Timing
- Latency is 1 cycle from the input handshake of a kept sample to `m_axis_out_tvalid`, when the buffer is empty.
- Throughput is 1 sample/cycle with `m_axis_out_tready` held high.
- While `tvalid && !tready`, `m_axis_out_tdata` and `m_axis_out_tlast` are held stable.
- `m_axis_out_tvalid` never drops without a handshake.
- A rate write takes effect at the first frame-start handshake on or after the cycle following the write.
- Output frames are always complete NUM_CHANNELS bursts. `tlast` appears exactly once per frame.

## Configuration
- Macro: `DOWNSAMPLER_PHASE_EN`.
- **Defined:**
  - the `s_axis_phase_tdata` port exists;
  - the phase is latched with each rate write and committed together with it;
  - `keep_idx = min(phase, R_eff-1)`;
  - reset phase is 0.
- **Undefined:** the port is absent and `keep_idx = R_eff-1`. This is the classic last-of-window keep.

## Structure
- Package `downsampler_pkg`:
  - `rate_t` (logic [DATA_WIDTH_RATE-1:0]);
  - the `chan_idx` width function `$clog2(NUM_CHANNELS)` guarded for 1;
  - the `RATE_RESET` = 1 constant.
- Sub-module `axis_skid_buffer` (params DATA_WIDTH), carrying {tdata, tlast}. It holds the output registers and generates `s_axis_in_tready`.
- The counter, keep and commit logic lives in the top.

## Test plan
- NUM_CHANNELS=2, R=3, inputs 1..12 with tready high → outputs (5,6),(11,12); `tlast` on 6 and 12; latency 1 cycle.
- R=0 and R=1 → every sample passes; `tlast` every 2nd sample.
- R=4 running, write R=2 mid-frame (after ch0 of frame 2) → frame 2 completes under R=4; the new window starts at the frame-3 boundary; the first kept frame is frame 4 (0-based).
- R=1, `m_axis_out_tready` toggled 1010…, continuous input → no sample lost or duplicated, data stable while stalled, `s_axis_in_tready` drops only with 2 entries full.
- With `DOWNSAMPLER_PHASE_EN`, R=4, phase=1 → frames 1,5,9 kept. Phase=7 → clamped to 3, so frames 3,7 are kept.
- Assert reset mid-frame with a full buffer → all outputs 0 asynchronously; after release, R=1 and the first accepted sample is ch0.

Source files
------------

// File: rtl/downsampler_pkg.sv
// Shared types and helpers for the TDM frame downsampler.
package downsampler_pkg;

    localparam int RATE_W_DEFAULT = 16;
    localparam int RATE_RESET     = 1;

    typedef logic [RATE_W_DEFAULT-1:0] rate_t;

    // Channel index width; a single-channel build still needs one bit.
    function automatic int chan_idx_w(input int num_channels);
        return (num_channels > 1) ? $clog2(num_channels) : 1;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer carrying {tdata, tlast}; owns the output registers.
module axis_skid_buffer #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] s_tdata,
    input  logic                         s_tlast,
    input  logic                         s_tvalid,
    output logic                         s_tready,
    output logic signed [DATA_WIDTH-1:0] m_tdata,
    output logic                         m_tlast,
    output logic                         m_tvalid,
    input  logic                         m_tready
);

    logic signed [DATA_WIDTH-1:0] out_data_p1;
    logic signed [DATA_WIDTH-1:0] skid_data_p1;
    logic                         out_last_p1;
    logic                         skid_last_p1;
    logic                         out_vld_p1;
    logic                         skid_vld_p1;
    logic                         push;
    logic                         pop;

    // Ready is registered-only, so upstream never sees a combinational path from m_tready.
    assign s_tready = !skid_vld_p1;
    assign push     = s_tvalid && s_tready;
    assign pop      = out_vld_p1 && m_tready;

    // Output stage (p1): skid entry refills the output slot before new input does.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_vld_p1   <= 1'b0;
            skid_vld_p1  <= 1'b0;
            out_data_p1  <= '0;
            out_last_p1  <= 1'b0;
            skid_data_p1 <= '0;
            skid_last_p1 <= 1'b0;
        end else if (!out_vld_p1 || pop) begin
            if (skid_vld_p1) begin
                out_data_p1 <= skid_data_p1;
                out_last_p1 <= skid_last_p1;
                out_vld_p1  <= 1'b1;
                skid_vld_p1 <= 1'b0;
            end else if (push) begin
                out_data_p1 <= s_tdata;
                out_last_p1 <= s_tlast;
                out_vld_p1  <= 1'b1;
            end else begin
                out_vld_p1  <= 1'b0;
            end
        end else if (push) begin
            skid_data_p1 <= s_tdata;
            skid_last_p1 <= s_tlast;
            skid_vld_p1  <= 1'b1;
        end
    end

    assign m_tdata  = out_data_p1;
    assign m_tlast  = out_last_p1;
    assign m_tvalid = out_vld_p1;

endmodule

// File: rtl/downsampler_variable_mc.sv
// Frame-aligned runtime-programmable TDM downsampler: keeps one N-channel frame per R.
// Optional DOWNSAMPLER_PHASE_EN adds a programmable kept-frame phase within the window.
module downsampler_variable_mc
    import downsampler_pkg::*;
#(
    parameter int DATA_WIDTH_INP  = 16,
    parameter int DATA_WIDTH_RATE = 16,
    parameter int NUM_CHANNELS    = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic signed [DATA_WIDTH_INP-1:0]  s_axis_in_tdata,
    input  logic                              s_axis_in_tvalid,
    output logic                              s_axis_in_tready,
    input  logic        [DATA_WIDTH_RATE-1:0] s_axis_rate_tdata,
    input  logic                              s_axis_rate_tvalid,
`ifdef DOWNSAMPLER_PHASE_EN
    input  logic        [DATA_WIDTH_RATE-1:0] s_axis_phase_tdata,
`endif
    output logic signed [DATA_WIDTH_INP-1:0]  m_axis_out_tdata,
    output logic                              m_axis_out_tvalid,
    input  logic                              m_axis_out_tready,
    output logic                              m_axis_out_tlast
);

    localparam int                   CW       = chan_idx_w(NUM_CHANNELS);
    localparam logic [CW-1:0]        LAST_CH  = CW'(NUM_CHANNELS - 1);
    localparam logic [DATA_WIDTH_RATE-1:0] RATE_ONE = DATA_WIDTH_RATE'(RATE_RESET);

    logic [CW-1:0]              chan_idx;
    logic [DATA_WIDTH_RATE-1:0] frame_cnt;
    logic [DATA_WIDTH_RATE-1:0] rate_buf;
    logic [DATA_WIDTH_RATE-1:0] rate_pending;
    logic                       pend;

    logic                       hs;
    logic                       commit;
    logic                       last_ch;
    logic                       keep;
    logic [DATA_WIDTH_RATE-1:0] rate_cur;
    logic [DATA_WIDTH_RATE-1:0] rate_m1;
    logic [DATA_WIDTH_RATE-1:0] frame_eval;
    logic [DATA_WIDTH_RATE-1:0] keep_idx;

    assign hs      = s_axis_in_tvalid && s_axis_in_tready;
    assign commit  = hs && (chan_idx == '0) && pend;
    assign last_ch = (chan_idx == LAST_CH);

    // A committing handshake already runs under the new rate, as frame 0 of the new window.
    assign rate_cur   = commit ? rate_pending : rate_buf;
    assign rate_m1    = (rate_cur == '0) ? '0 : rate_cur - RATE_ONE;
    assign frame_eval = commit ? '0 : frame_cnt;

`ifdef DOWNSAMPLER_PHASE_EN
    logic [DATA_WIDTH_RATE-1:0] phase_buf;
    logic [DATA_WIDTH_RATE-1:0] phase_pending;
    logic [DATA_WIDTH_RATE-1:0] phase_cur;

    assign phase_cur = commit ? phase_pending : phase_buf;
    assign keep_idx  = (phase_cur < rate_m1) ? phase_cur : rate_m1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_buf     <= '0;
            phase_pending <= '0;
        end else begin
            if (s_axis_rate_tvalid) begin
                phase_pending <= s_axis_phase_tdata;
            end
            if (commit) begin
                phase_buf <= phase_pending;
            end
        end
    end
`else
    assign keep_idx = rate_m1;
`endif

    assign keep = (frame_eval == keep_idx);

    // Input stage (p0): frame counters and rate commit on accepted samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chan_idx     <= '0;
            frame_cnt    <= '0;
            rate_buf     <= RATE_ONE;
            rate_pending <= RATE_ONE;
            pend         <= 1'b0;
        end else begin
            if (hs) begin
                if (last_ch) begin
                    chan_idx  <= '0;
                    frame_cnt <= (frame_eval >= rate_m1) ? '0 : frame_eval + RATE_ONE;
                end else begin
                    chan_idx  <= chan_idx + CW'(1);
                    frame_cnt <= frame_eval;
                end
            end
            if (commit) begin
                rate_buf <= rate_pending;
            end
            // A write coinciding with a commit stays pending for the next frame boundary.
            if (s_axis_rate_tvalid) begin
                rate_pending <= s_axis_rate_tdata;
                pend         <= 1'b1;
            end else if (commit) begin
                pend <= 1'b0;
            end
        end
    end

    axis_skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH_INP)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .s_tdata  (s_axis_in_tdata),
        .s_tlast  (last_ch),
        .s_tvalid (hs && keep),
        .s_tready (s_axis_in_tready),
        .m_tdata  (m_axis_out_tdata),
        .m_tlast  (m_axis_out_tlast),
        .m_tvalid (m_axis_out_tvalid),
        .m_tready (m_axis_out_tready)
    );

endmodule

// File: tb/tb_downsampler_variable_mc.sv
// Scoreboard bench for downsampler_variable_mc (NUM_CHANNELS=2); phase cases need DOWNSAMPLER_PHASE_EN.
module tb_downsampler_variable_mc;

    localparam int NC = 2;
`ifdef DOWNSAMPLER_PHASE_EN
    localparam bit PH_EN = 1'b1;
`else
    localparam bit PH_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] s_axis_in_tdata;
    logic               s_axis_in_tvalid;
    logic               s_axis_in_tready;
    logic        [15:0] s_axis_rate_tdata;
    logic               s_axis_rate_tvalid;
    logic        [15:0] s_axis_phase_tdata;
    logic signed [15:0] m_axis_out_tdata;
    logic               m_axis_out_tvalid;
    logic               m_axis_out_tready;
    logic               m_axis_out_tlast;

    always #5 clk = ~clk;

    downsampler_variable_mc #(
        .DATA_WIDTH_INP  (16),
        .DATA_WIDTH_RATE (16),
        .NUM_CHANNELS    (NC)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .s_axis_in_tdata    (s_axis_in_tdata),
        .s_axis_in_tvalid   (s_axis_in_tvalid),
        .s_axis_in_tready   (s_axis_in_tready),
        .s_axis_rate_tdata  (s_axis_rate_tdata),
        .s_axis_rate_tvalid (s_axis_rate_tvalid),
`ifdef DOWNSAMPLER_PHASE_EN
        .s_axis_phase_tdata (s_axis_phase_tdata),
`endif
        .m_axis_out_tdata   (m_axis_out_tdata),
        .m_axis_out_tvalid  (m_axis_out_tvalid),
        .m_axis_out_tready  (m_axis_out_tready),
        .m_axis_out_tlast   (m_axis_out_tlast)
    );

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } item_t;

    item_t q[$];
    item_t got[$];

    int vectors = 0;
    int errors  = 0;

    // Reference model state
    int          m_chan, m_frame, m_rate, m_rpend, m_ph, m_phpend;
    bit          m_pend;
    logic [15:0] ph_d;
    bit          saw_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_chan = 0; m_frame = 0; m_rate = 1; m_rpend = 1;
        m_ph = 0; m_phpend = 0; m_pend = 1'b0;
    endtask

    // One clock: drive, predict, clock, then check every output against the model.
    task automatic step(input bit vin, input logic [15:0] din, input bit rv,
                        input logic [15:0] rd, input bit ordy, output bit hs);
        bit  pop, push;
        int  reff, rm1, kidx;
        item_t it;
        s_axis_in_tvalid   = vin;
        s_axis_in_tdata    = din;
        s_axis_rate_tvalid = rv;
        s_axis_rate_tdata  = rd;
        s_axis_phase_tdata = ph_d;
        m_axis_out_tready  = ordy;
        #1;
        hs   = vin && s_axis_in_tready;
        if (!s_axis_in_tready) saw_stall = 1'b1;
        pop  = (q.size() > 0) && ordy;
        push = 1'b0;
        if (hs) begin
            if (m_chan == 0 && m_pend) begin
                m_rate = m_rpend; m_ph = m_phpend; m_frame = 0; m_pend = 1'b0;
            end
            reff = (m_rate == 0) ? 1 : m_rate;
            rm1  = reff - 1;
            kidx = (PH_EN && m_ph < rm1) ? m_ph : rm1;
            push = (m_frame == kidx);
            it.d = din;
            it.l = (m_chan == NC - 1);
            if (m_chan == NC - 1) begin
                m_chan  = 0;
                m_frame = (m_frame >= rm1) ? 0 : m_frame + 1;
            end else begin
                m_chan++;
            end
        end
        if (rv) begin
            m_rpend = rd; m_phpend = ph_d; m_pend = 1'b1;
        end
        @(posedge clk);
        #1;
        if (pop) got.push_back(q.pop_front());
        if (push) q.push_back(it);
        chk("tvalid", m_axis_out_tvalid, q.size() > 0);
        if (q.size() > 0) begin
            chk("tdata", m_axis_out_tdata, q[0].d);
            chk("tlast", m_axis_out_tlast, q[0].l);
        end
        chk("in_tready", s_axis_in_tready, q.size() < 2);
    endtask

    task automatic drain();
        bit hs;
        for (int i = 0; i < 20 && q.size() > 0; i++) step(1'b0, 16'd0, 1'b0, 16'd0, 1'b1, hs);
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic write_rate(input logic [15:0] r);
        bit hs;
        step(1'b0, 16'd0, 1'b1, r, 1'b1, hs);
    endtask

    task automatic feed(input logic [15:0] first, input int n);
        bit hs;
        for (int i = 0; i < n; i++) step(1'b1, first + 16'(i), 1'b0, 16'd0, 1'b1, hs);
    endtask

    initial begin
        bit          hs;
        logic [15:0] d;
        int          acc;
        reset = 1'b1;
        ph_d  = 16'd0;
        s_axis_in_tvalid = 1'b0; s_axis_in_tdata = '0;
        s_axis_rate_tvalid = 1'b0; s_axis_rate_tdata = '0;
        s_axis_phase_tdata = '0; m_axis_out_tready = 1'b1;
        model_reset();
        saw_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", m_axis_out_tvalid, 1'b0);
        chk("rst_tdata", m_axis_out_tdata, 16'd0);
        chk("rst_tlast", m_axis_out_tlast, 1'b0);
        reset = 1'b0;
        #1;
        chk("rst_tready", s_axis_in_tready, 1'b1);

        // R=3: keep frames 2 and 5 of inputs 1..12
        got.delete();
        write_rate(16'd3);
        feed(16'd1, 12);
        drain();
        chk("r3_count", got.size(), 4);
        if (got.size() == 4) begin
            chk("r3_d0", got[0].d, 16'd5);  chk("r3_l0", got[0].l, 1'b0);
            chk("r3_d1", got[1].d, 16'd6);  chk("r3_l1", got[1].l, 1'b1);
            chk("r3_d2", got[2].d, 16'd11); chk("r3_l2", got[2].l, 1'b0);
            chk("r3_d3", got[3].d, 16'd12); chk("r3_l3", got[3].l, 1'b1);
        end

        // R=0 behaves as pass-through
        got.delete();
        write_rate(16'd0);
        feed(16'd21, 6);
        drain();
        chk("r0_count", got.size(), 6);
        if (got.size() == 6) begin
            chk("r0_d5", got[5].d, 16'd26);
            chk("r0_l4", got[4].l, 1'b0);
            chk("r0_l5", got[5].l, 1'b1);
        end

        // R=1 pass-through
        got.delete();
        write_rate(16'd1);
        feed(16'd31, 4);
        drain();
        chk("r1_count", got.size(), 4);
        if (got.size() == 4) begin
            chk("r1_d0", got[0].d, 16'd31);
            chk("r1_l1", got[1].l, 1'b1);
        end

        // R=4 running, R=2 written after ch0 of frame 2: kept frames 4 and 6
        got.delete();
        write_rate(16'd4);
        feed(16'd100, 2); feed(16'd110, 2); feed(16'd120, 1);
        write_rate(16'd2);
        feed(16'd121, 1); feed(16'd130, 2); feed(16'd140, 2);
        feed(16'd150, 2); feed(16'd160, 2);
        drain();
        chk("rchg_count", got.size(), 4);
        if (got.size() == 4) begin
            chk("rchg_d0", got[0].d, 16'd140);
            chk("rchg_d1", got[1].d, 16'd141);
            chk("rchg_d2", got[2].d, 16'd160);
            chk("rchg_l3", got[3].l, 1'b1);
        end

        // R=1 with output ready toggling 1010 and continuous input
        got.delete();
        write_rate(16'd1);
        saw_stall = 1'b0;
        d = 16'd300; acc = 0;
        for (int i = 0; i < 24; i++) begin
            step(1'b1, d, 1'b0, 16'd0, (i % 2) == 0, hs);
            if (hs) begin d++; acc++; end
        end
        drain();
        chk("bp_count", got.size(), acc);
        for (int k = 0; k < got.size(); k++) chk("bp_order", got[k].d, 16'(300 + k));
        chk("bp_stall_seen", saw_stall, 1'b1);

        if (PH_EN) begin
            // phase=1, R=4: frames 1,5,9; then phase=7 clamps to 3: frames 3,7
            got.delete();
            ph_d = 16'd1;
            write_rate(16'd4);
            feed(16'd400, 2 * NC * 5);
            drain();
            chk("ph1_count", got.size(), 6);
            if (got.size() == 6) begin
                chk("ph1_d0", got[0].d, 16'd402);
                chk("ph1_d2", got[2].d, 16'd410);
                chk("ph1_d4", got[4].d, 16'd418);
            end
            got.delete();
            ph_d = 16'd7;
            write_rate(16'd4);
            feed(16'd500, 16);
            drain();
            chk("ph7_count", got.size(), 4);
            if (got.size() == 4) begin
                chk("ph7_d0", got[0].d, 16'd506);
                chk("ph7_d2", got[2].d, 16'd514);
            end
            ph_d = 16'd0;
        end

        // Mid-frame reset with a full buffer
        got.delete();
        write_rate(16'd1);
        step(1'b1, 16'd601, 1'b0, 16'd0, 1'b1, hs);
        step(1'b1, 16'd602, 1'b0, 16'd0, 1'b1, hs);
        step(1'b1, 16'd603, 1'b0, 16'd0, 1'b0, hs);
        chk("pre_rst_full", s_axis_in_tready, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_tvalid", m_axis_out_tvalid, 1'b0);
        chk("arst_tdata", m_axis_out_tdata, 16'd0);
        chk("arst_tlast", m_axis_out_tlast, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        got.delete();
        feed(16'd700, 2);
        drain();
        chk("post_rst_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("post_rst_d0", got[0].d, 16'd700);
            chk("post_rst_l0", got[0].l, 1'b0);
            chk("post_rst_l1", got[1].l, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
